// File: rtl/nibble_addsub_pkg.sv
// Shared types and helpers for the nibble-serial adder/subtractor.
package nibble_addsub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int SLICE_W = 4;

  // Merge a new (higher) slice into the running group generate of the lower slices.
  function automatic logic gg_combine(input logic slice_gg,
                                      input logic slice_pg,
                                      input logic gg_acc);
    return slice_gg | (slice_pg & gg_acc);
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice. It exposes c3 so the caller can
// derive signed overflow.
module cla4_slice
  import nibble_addsub_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c3,
  output logic       cout,
  output logic       pg,
  output logic       gg
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [3:0] c_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Lookahead carries, sums and group propagate/generate
  always_comb begin
    c_s[0] = cin;
    c_s[1] = g_s[0] | (p_s[0] & cin);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & cin);
    pg     = &p_s;
    gg     = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
    cout   = gg | (pg & cin);
    c3     = c_s[3];
    s      = p_s ^ c_s;
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// W-bit add/subtract built from one reused 4-bit CLA slice, one nibble per
// clock, LSB first, with a start/busy/done handshake.
module nibble_serial_addsub
  import nibble_addsub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   ovf,
  output logic                   zero,
  output logic                   pg,
  output logic                   gg
);

  localparam int W    = SLICE_W * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t            state_r;
  state_t            state_next_s;
  logic [IDXW-1:0]   idx_r;
  logic [W-1:0]      op_a_r;
  logic [W-1:0]      op_b_r;
  logic              carry_r;
  logic              pg_acc_r;
  logic              gg_acc_r;
  logic [W-1:0]      result_r;
  logic              cout_r;
  logic              ovf_r;
  logic              zero_r;
  logic              pg_r;
  logic              gg_r;
  logic              busy_r;
  logic              done_r;

  logic [3:0]        slice_a_s;
  logic [3:0]        slice_b_s;
  logic [3:0]        slice_sum_s;
  logic              slice_c3_s;
  logic              slice_cout_s;
  logic              slice_pg_s;
  logic              slice_gg_s;
  logic              last_s;
  logic              pg_next_s;
  logic              gg_next_s;
  logic [W-1:0]      result_next_s;

  assign slice_a_s = op_a_r[SLICE_W*idx_r +: SLICE_W];
  assign slice_b_s = op_b_r[SLICE_W*idx_r +: SLICE_W];
  assign last_s    = (idx_r == IDXW'(NIBBLES - 1));

  cla4_slice u_slice (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .cin  (carry_r),
    .s    (slice_sum_s),
    .c3   (slice_c3_s),
    .cout (slice_cout_s),
    .pg   (slice_pg_s),
    .gg   (slice_gg_s)
  );

  // Word-level result and accumulator values after folding in the current slice
  always_comb begin
    result_next_s = result_r;
    result_next_s[SLICE_W*idx_r +: SLICE_W] = slice_sum_s;
    pg_next_s = pg_acc_r & slice_pg_s;
    gg_next_s = gg_combine(slice_gg_s, slice_pg_s, gg_acc_r);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      RUN: begin
        if (last_s) state_next_s = IDLE;
        else        state_next_s = RUN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Operand capture, per-nibble datapath and registered result flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r    <= {IDXW{1'b0}};
      op_a_r   <= {W{1'b0}};
      op_b_r   <= {W{1'b0}};
      carry_r  <= 1'b0;
      pg_acc_r <= 1'b0;
      gg_acc_r <= 1'b0;
      result_r <= {W{1'b0}};
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
      pg_r     <= 1'b0;
      gg_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            // Subtraction as a + ~b + 1: invert B here, carry-in from sub
            op_a_r   <= a;
            op_b_r   <= b ^ {W{sub}};
            carry_r  <= sub;
            pg_acc_r <= 1'b1;
            gg_acc_r <= 1'b0;
            idx_r    <= {IDXW{1'b0}};
            busy_r   <= 1'b1;
          end
        end
        RUN: begin
          result_r <= result_next_s;
          carry_r  <= slice_cout_s;
          pg_acc_r <= pg_next_s;
          gg_acc_r <= gg_next_s;
          idx_r    <= idx_r + 1'b1;
          if (last_s) begin
            cout_r <= slice_cout_s;
            ovf_r  <= slice_c3_s ^ slice_cout_s;
            zero_r <= (result_next_s == {W{1'b0}});
            pg_r   <= pg_next_s;
            gg_r   <= gg_next_s;
            idx_r  <= {IDXW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign cout   = cout_r;
  assign ovf    = ovf_r;
  assign zero   = zero_r;
  assign pg     = pg_r;
  assign gg     = gg_r;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub at the default width (16 bits).
module tb_nibble_serial_addsub;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        pg;
  logic        gg;

  int n_cmp = 0;
  int n_err = 0;

  nibble_serial_addsub #(.NIBBLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero),
    .pg     (pg),
    .gg     (gg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic sv);
    a = av;
    b = bv;
    sub = sv;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic chk_res(input string tag, input logic [15:0] r, input logic c,
                         input logic o, input logic z, input logic p, input logic g);
    chk({tag, ".result"}, 32'(result), 32'(r));
    chk({tag, ".cout"},   32'(cout),   32'(c));
    chk({tag, ".ovf"},    32'(ovf),    32'(o));
    chk({tag, ".zero"},   32'(zero),   32'(z));
    chk({tag, ".pg"},     32'(pg),     32'(p));
    chk({tag, ".gg"},     32'(gg),     32'(g));
  endtask

  initial begin
    int lat;
    int lat2;
    int pulses;

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = 16'h0000;
    b     = 16'h0000;
    repeat (2) step();
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk_res("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // 0x0001 + 0x0000
    launch(16'h0001, 16'h0000, 1'b0);
    chk("add1.busy", 32'(busy), 32'd1);
    wait_done(lat);
    chk("add1.latency", 32'(lat), 32'd4);
    chk("add1.busy_at_done", 32'(busy), 32'd0);
    chk_res("add1", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("add1.done_width", 32'(done), 32'd0);
    chk("add1.hold", 32'(result), 32'h0001);

    // 0xFFFF + 0x0001
    launch(16'hFFFF, 16'h0001, 1'b0);
    wait_done(lat);
    chk("add2.latency", 32'(lat), 32'd4);
    chk_res("add2", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step();

    // 0x7FFF + 0x0001
    launch(16'h7FFF, 16'h0001, 1'b0);
    wait_done(lat);
    chk("add3.latency", 32'(lat), 32'd4);
    chk_res("add3", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    // 0x00F0 + 0xFF0F
    launch(16'h00F0, 16'hFF0F, 1'b0);
    wait_done(lat);
    chk("add4.latency", 32'(lat), 32'd4);
    chk_res("add4", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();

    // 0x0005 - 0x0007
    launch(16'h0005, 16'h0007, 1'b1);
    wait_done(lat);
    chk("sub1.latency", 32'(lat), 32'd4);
    chk_res("sub1", 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // 0x8000 - 0x0001
    launch(16'h8000, 16'h0001, 1'b1);
    wait_done(lat);
    chk("sub2.latency", 32'(lat), 32'd4);
    chk_res("sub2", 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();

    // start pulsed two cycles into an operation is ignored
    launch(16'h1234, 16'h1111, 1'b0);
    step();
    a = 16'hAAAA;
    b = 16'h5555;
    sub = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(lat);
    chk("ign.latency", 32'(lat + 2), 32'd4);
    chk_res("ign", 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    chk("ign.no_queue", 32'(pulses), 32'd0);
    chk("ign.busy", 32'(busy), 32'd0);

    // back-to-back start in the done cycle
    launch(16'h0003, 16'h0004, 1'b0);
    wait_done(lat);
    chk("b2b1.latency", 32'(lat), 32'd4);
    chk("b2b1.result", 32'(result), 32'h0007);
    launch(16'h1000, 16'h0001, 1'b1);
    chk("b2b2.accepted", 32'(busy), 32'd1);
    wait_done(lat2);
    chk("b2b2.gap", 32'(lat2 + 1), 32'd5);
    chk("b2b2.result", 32'(result), 32'h0FFF);
    chk("b2b2.cout", 32'(cout), 32'd1);
    chk("b2b2.ovf", 32'(ovf), 32'd0);
    step();

    // reset during RUN at idx=2 abandons the operation
    launch(16'h1111, 16'h2222, 1'b0);
    step();
    step();
    chk("mid.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.done", 32'(done), 32'd0);
    chk_res("mid", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    chk("mid.no_done", 32'(pulses), 32'd0);

    launch(16'h0010, 16'h0020, 1'b0);
    wait_done(lat);
    chk("post.latency", 32'(lat), 32'd4);
    chk_res("post", 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("post.done_width", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
